// File: rtl/hqm_rcfwl_gclk_pde_seq_pkg.sv
// Shared types and helpers for the PDE clock-tap enable sequencer.
package hqm_rcfwl_gclk_pde_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_STEP      = 2'd2,
    ST_SETTLE    = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_TAP     = 4;
  localparam int DEF_STAGGER_CYC = 8;
  localparam int DEF_SYNC_TMO    = 255;
  localparam int DEF_CNT_W       = 8;
  localparam int MAX_TAP         = 16;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lsb_idx(input logic [MAX_TAP-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_TAP - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_pde_seq_ctrl_if.sv
// Request/enable/ack bundle between the tap sequencer and its requester.
interface hqm_rcfwl_gclk_pde_seq_ctrl_if
  import hqm_rcfwl_gclk_pde_seq_pkg::*;
#(
  parameter int NUM_TAP = DEF_NUM_TAP
);
  logic               pll_sync_in;
  logic [NUM_TAP-1:0] tap_req;
  logic [NUM_TAP-1:0] tap_en;
  logic [NUM_TAP-1:0] tap_ack;
  logic               busy;
  logic               sync_tmo_err;
  logic               err_clr;

  modport master (
    output pll_sync_in, tap_req, err_clr,
    input  tap_en, tap_ack, busy, sync_tmo_err
  );

  modport slave (
    input  pll_sync_in, tap_req, err_clr,
    output tap_en, tap_ack, busy, sync_tmo_err
  );
endinterface

// File: rtl/hqm_rcfwl_gclk_pde_dncnt.sv
// Shared load/increment/decrement counter with zero and compare-match flags.
module hqm_rcfwl_gclk_pde_dncnt
  import hqm_rcfwl_gclk_pde_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_match_val,
  output logic             o_zero,
  output logic             o_match
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero  = (r_cnt == '0);
  assign o_match = (r_cnt == i_match_val);
endmodule

// File: rtl/hqm_rcfwl_gclk_pde_seq_ctrl.sv
// Sequences PDE clock-tap enables one tap at a time after pll_sync, with a settle
// stagger between taps and a level req/ack handshake per tap.
module hqm_rcfwl_gclk_pde_seq_ctrl
  import hqm_rcfwl_gclk_pde_seq_pkg::*;
#(
  parameter int NUM_TAP     = DEF_NUM_TAP,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC,
  parameter int SYNC_TMO    = DEF_SYNC_TMO,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                          clk,
  input logic                          rst_b,
  hqm_rcfwl_gclk_pde_seq_ctrl_if.slave bus
);
  localparam int               IDX_W    = (NUM_TAP > 1) ? $clog2(NUM_TAP) : 1;
  localparam logic [CNT_W-1:0] STG_LOAD = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(SYNC_TMO - 1);

  seq_state_e         r_state;
  logic [NUM_TAP-1:0] r_target;
  logic [NUM_TAP-1:0] r_tap_en;
  logic [NUM_TAP-1:0] r_tap_ack;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_err;

  logic [NUM_TAP-1:0] w_diff;
  logic               w_found;
  logic               w_start;
  logic [IDX_W-1:0]   w_idx;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_load_val;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic               w_cnt_match;

  assign w_diff  = r_target ^ r_tap_en;
  assign w_found = |w_diff;
  assign w_idx   = IDX_W'(lsb_idx(MAX_TAP'(w_diff)));
  assign w_start = (bus.tap_req != r_tap_ack);

  // One counter serves both the sync timeout (counting up) and the stagger (counting down).
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_inc      = 1'b0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      ST_IDLE:      w_cnt_load = w_start;
      ST_WAIT_SYNC: w_cnt_inc  = !bus.pll_sync_in && !w_cnt_match;
      ST_STEP: begin
        w_cnt_load     = w_found;
        w_cnt_load_val = STG_LOAD;
      end
      ST_SETTLE:    w_cnt_dec  = !w_cnt_zero;
      default:      ;
    endcase
  end

  hqm_rcfwl_gclk_pde_dncnt #(.CNT_W(CNT_W)) u_cnt (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_load      (w_cnt_load),
    .i_load_val  (w_cnt_load_val),
    .i_inc       (w_cnt_inc),
    .i_dec       (w_cnt_dec),
    .i_match_val (TMO_LAST),
    .o_zero      (w_cnt_zero),
    .o_match     (w_cnt_match)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_IDLE;
      r_target  <= '0;
      r_tap_en  <= '0;
      r_tap_ack <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (bus.err_clr) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_target <= bus.tap_req;
            r_busy   <= 1'b1;
            r_state  <= ST_WAIT_SYNC;
          end
        end
        ST_WAIT_SYNC: begin
          if (bus.pll_sync_in) begin
            r_state <= ST_STEP;
          end else if (w_cnt_match) begin
            r_err   <= 1'b1;
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (w_found) begin
            r_tap_en[w_idx] <= r_target[w_idx];
            r_idx           <= w_idx;
            r_state         <= ST_SETTLE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            r_tap_ack[r_idx] <= r_tap_en[r_idx];
            r_state          <= ST_STEP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tap_en       = r_tap_en;
  assign bus.tap_ack      = r_tap_ack;
  assign bus.busy         = r_busy;
  assign bus.sync_tmo_err = r_err;
endmodule

// File: tb/tb_hqm_rcfwl_gclk_pde_seq_ctrl.sv
// Bench for the PDE tap sequencer: expected enables/acks come from the sync-relative
// timeline (toggle at +2, ack at +2+STAGGER, spacing STAGGER+1) applied to the changed bits.
module tb_hqm_rcfwl_gclk_pde_seq_ctrl;
  localparam int NUM_TAP     = 4;
  localparam int STAGGER_CYC = 8;
  localparam int SYNC_TMO    = 255;
  localparam int CNT_W       = 8;
  localparam int SPACING     = STAGGER_CYC + 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] m_en;
  bit   m_err;

  hqm_rcfwl_gclk_pde_seq_ctrl_if #(.NUM_TAP(NUM_TAP)) bus ();

  hqm_rcfwl_gclk_pde_seq_ctrl #(
    .NUM_TAP     (NUM_TAP),
    .STAGGER_CYC (STAGGER_CYC),
    .SYNC_TMO    (SYNC_TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives tap_req=t in the current (IDLE) cycle, then either a sync pulse dly cycles
  // later or no sync at all (timeout), and checks every cycle until busy drops.
  task automatic run_seq(input logic [3:0] t, input int dly, input bit tmo, input bit sync_det,
                         input bit clr_m, input bit mid_en, input logic [3:0] mid, input int rst_d);
    int         bits[$];
    int         m;
    int         last;
    logic [3:0] diff;
    logic [3:0] e_en;
    logic [3:0] e_ack;
    bit         e_err;
    diff = t ^ m_en;
    for (int i = 0; i < 4; i++) if (diff[i]) bits.push_back(i);
    m = tmo ? SYNC_TMO : dly;
    bus.tap_req     = t;
    bus.pll_sync_in = sync_det;
    for (int c = 1; c <= m; c++) begin
      tick();
      bus.pll_sync_in = 1'b0;
      chk("wait_busy", 32'(bus.busy), 32'd1);
      chk("wait_en", 32'(bus.tap_en), 32'(m_en));
      chk("wait_ack", 32'(bus.tap_ack), 32'(m_en));
      chk("wait_err", 32'(bus.sync_tmo_err), 32'(m_err));
      if (c == m) begin
        bus.pll_sync_in = !tmo;
        bus.err_clr     = clr_m;
      end
    end
    e_err = tmo ? 1'b1 : (clr_m ? 1'b0 : m_err);
    last  = 2 + SPACING * bits.size();
    for (int d = 1; d <= last; d++) begin
      tick();
      bus.pll_sync_in = 1'b0;
      bus.err_clr     = 1'b0;
      e_en  = m_en;
      e_ack = m_en;
      foreach (bits[j]) begin
        if (d >= 2 + SPACING * j)               e_en  = e_en  ^ (4'b0001 << bits[j]);
        if (d >= 2 + STAGGER_CYC + SPACING * j) e_ack = e_ack ^ (4'b0001 << bits[j]);
      end
      chk("seq_en", 32'(bus.tap_en), 32'(e_en));
      chk("seq_ack", 32'(bus.tap_ack), 32'(e_ack));
      chk("seq_busy", 32'(bus.busy), 32'(d < last));
      chk("seq_err", 32'(bus.sync_tmo_err), 32'(e_err));
      if (mid_en && d == 3) bus.tap_req = mid;
      if (d == rst_d) begin
        #2 rst_b = 1'b0;
        #1;
        chk("arst_en", 32'(bus.tap_en), 32'd0);
        chk("arst_ack", 32'(bus.tap_ack), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_err", 32'(bus.sync_tmo_err), 32'd0);
        m_en  = 4'h0;
        m_err = 1'b0;
        return;
      end
    end
    m_en  = t;
    m_err = e_err;
  endtask

  task automatic clr_pulse();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.sync_tmo_err), 32'd0);
    m_err = 1'b0;
  endtask

  initial begin
    bus.tap_req     = 4'hF;
    bus.pll_sync_in = 1'b0;
    bus.err_clr     = 1'b0;
    m_en  = 4'h0;
    m_err = 1'b0;

    // reset with all taps requested, then a timeout-started sequence
    repeat (3) tick();
    chk("rst_en", 32'(bus.tap_en), 32'd0);
    chk("rst_ack", 32'(bus.tap_ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.sync_tmo_err), 32'd0);
    rst_b = 1'b1;
    run_seq(4'hF, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    clr_pulse();

    // enable all with sync ten cycles after the request
    run_seq(4'h0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    run_seq(4'hF, 10, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);

    // timeout, clear, then clear colliding with a fresh timeout
    run_seq(4'h1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    clr_pulse();
    run_seq(4'h3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 0);
    clr_pulse();

    // request change during tap0 settle, followed by the follow-up sequence
    run_seq(4'h0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    run_seq(4'h3, 4, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 0);
    run_seq(4'hC, 6, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);

    // sync in detect cycle ignored; sync on the timeout cycle gives no error
    run_seq(4'h3, 3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0);
    run_seq(4'h0, SYNC_TMO, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);

    for (int r = 0; r < 10; r++) begin
      logic [3:0] t;
      t = m_en ^ 4'($urandom_range(1, 15));
      run_seq(t, int'($urandom_range(1, 20)), 1'b0, 1'($urandom_range(0, 1)),
              1'b0, 1'b0, 4'h0, 0);
    end

    // async reset while tap2 is settling, then a full restart from tap0
    if (m_en != 4'h0) run_seq(4'h0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    run_seq(4'hF, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2 + 2 * SPACING + 3);
    tick();
    rst_b = 1'b1;
    run_seq(4'hF, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
